demux_1_2_stream: RTL and testbench

DEMUX_1_2_STREAM -- requirements
Module: demux_1_2_stream

---
 rtl/demux_1_2_stream.sv | 92 +++++++++
 tb/tb_demux_1_2_stream.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_2_stream.sv
// One-to-two stream demultiplexer: each accepted input word is routed by IN_SEL
// into a single-entry output buffer for A or B. Each output keeps a count of completed transfers.
module demux_1_2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_SEL,
  output logic             IN_READY,
  output logic [WIDTH-1:0] A_DATA,
  output logic             A_VALID,
  input  logic             A_READY,
  output logic [WIDTH-1:0] B_DATA,
  output logic             B_VALID,
  input  logic             B_READY,
  output logic [CNT_W-1:0] A_CNT,
  output logic [CNT_W-1:0] B_CNT
);

  logic [WIDTH-1:0] r_aData;
  logic             r_aValid;
  logic [CNT_W-1:0] r_aCnt;
  logic [WIDTH-1:0] r_bData;
  logic             r_bValid;
  logic [CNT_W-1:0] r_bCnt;

  logic w_aFree;
  logic w_bFree;
  logic w_accept;
  logic w_loadA;
  logic w_loadB;
  logic w_xferA;
  logic w_xferB;

  // A buffer is free if it is empty or its word leaves on this edge.
  assign w_aFree  = !r_aValid || A_READY;
  assign w_bFree  = !r_bValid || B_READY;
  assign IN_READY = IN_SEL ? w_bFree : w_aFree;

  assign w_accept = IN_VALID && IN_READY;
  assign w_loadA  = w_accept && !IN_SEL;
  assign w_loadB  = w_accept && IN_SEL;
  assign w_xferA  = r_aValid && A_READY;
  assign w_xferB  = r_bValid && B_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_aData  <= '0;
      r_aValid <= 1'b0;
      r_aCnt   <= '0;
    end else begin
      if (w_loadA) begin
        r_aData  <= IN_DATA;
        r_aValid <= 1'b1;
      end else if (w_xferA) begin
        r_aValid <= 1'b0;
      end
      if (w_xferA) begin
        r_aCnt <= r_aCnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bData  <= '0;
      r_bValid <= 1'b0;
      r_bCnt   <= '0;
    end else begin
      if (w_loadB) begin
        r_bData  <= IN_DATA;
        r_bValid <= 1'b1;
      end else if (w_xferB) begin
        r_bValid <= 1'b0;
      end
      if (w_xferB) begin
        r_bCnt <= r_bCnt + CNT_W'(1);
      end
    end
  end

  assign A_DATA  = r_aData;
  assign A_VALID = r_aValid;
  assign A_CNT   = r_aCnt;
  assign B_DATA  = r_bData;
  assign B_VALID = r_bValid;
  assign B_CNT   = r_bCnt;

endmodule

// File: tb/tb_demux_1_2_stream.sv
// Directed testbench for demux_1_2_stream: reset, routing, back-pressure,
// streaming, output independence, counter wrap and reset during operation.
module tb_demux_1_2_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inData;
  logic       inValid;
  logic       inSel;
  logic       inReady;
  logic [7:0] aData;
  logic       aValid;
  logic       aReady;
  logic [7:0] bData;
  logic       bValid;
  logic       bReady;
  logic [7:0] aCnt;
  logic [7:0] bCnt;

  int vectors = 0;
  int miscompares = 0;

  demux_1_2_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst),
    .IN_DATA(inData), .IN_VALID(inValid), .IN_SEL(inSel), .IN_READY(inReady),
    .A_DATA(aData), .A_VALID(aValid), .A_READY(aReady),
    .B_DATA(bData), .B_VALID(bValid), .B_READY(bReady),
    .A_CNT(aCnt), .B_CNT(bCnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1; inValid = 1'b0; inSel = 1'b0; inData = 8'h00;
    aReady = 1'b0; bReady = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b1; inSel = 1'b0; inData = 8'hFF;
    aReady = 1'b0; bReady = 1'b0;
    tick();
    tick();
    vectors++;
    if (inReady !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b expected 1", inReady); miscompares++;
    end
    rst = 1'b0; inValid = 1'b0;
    tick();
    vectors++;
    if ({aValid, bValid} !== 2'b00) begin
      $display("FAIL reset_valid: got %b expected 00", {aValid, bValid}); miscompares++;
    end
    vectors++;
    if ({aData, bData} !== 16'h0000) begin
      $display("FAIL reset_data: got %h expected 0000", {aData, bData}); miscompares++;
    end
    vectors++;
    if ({aCnt, bCnt} !== 16'h0000) begin
      $display("FAIL reset_cnt: got %h expected 0000", {aCnt, bCnt}); miscompares++;
    end
  endtask

  task automatic test_single();
    resetDut();
    aReady = 1'b1; inData = 8'h5A; inSel = 1'b0; inValid = 1'b1;
    #1;
    vectors++;
    if (inReady !== 1'b1) begin
      $display("FAIL single_in_ready: got %b expected 1", inReady); miscompares++;
    end
    tick();
    inValid = 1'b0;
    vectors++;
    if ({aValid, aData, bValid} !== {1'b1, 8'h5A, 1'b0}) begin
      $display("FAIL single_route: got a_valid=%b a_data=%h b_valid=%b expected 1 5a 0",
               aValid, aData, bValid); miscompares++;
    end
    vectors++;
    if (aCnt !== 8'd0) begin
      $display("FAIL single_cnt_before: got %0d expected 0", aCnt); miscompares++;
    end
    tick();
    vectors++;
    if ({aCnt, aValid} !== {8'd1, 1'b0}) begin
      $display("FAIL single_cnt_after: got cnt=%0d valid=%b expected 1 0", aCnt, aValid); miscompares++;
    end
  endtask

  task automatic test_backpressure();
    resetDut();
    bReady = 1'b0; inSel = 1'b1; inData = 8'h11; inValid = 1'b1;
    #1;
    vectors++;
    if (inReady !== 1'b1) begin
      $display("FAIL bp_first_ready: got %b expected 1", inReady); miscompares++;
    end
    tick();
    inData = 8'h22;
    #1;
    vectors++;
    if (inReady !== 1'b0) begin
      $display("FAIL bp_second_ready: got %b expected 0", inReady); miscompares++;
    end
    tick();
    vectors++;
    if ({bValid, bData, inReady} !== {1'b1, 8'h11, 1'b0}) begin
      $display("FAIL bp_hold: got valid=%b data=%h ready=%b expected 1 11 0",
               bValid, bData, inReady); miscompares++;
    end
    bReady = 1'b1;
    #1;
    vectors++;
    if (inReady !== 1'b1) begin
      $display("FAIL bp_release_ready: got %b expected 1", inReady); miscompares++;
    end
    tick();
    inValid = 1'b0;
    vectors++;
    if ({bValid, bData, bCnt} !== {1'b1, 8'h22, 8'd1}) begin
      $display("FAIL bp_first_out: got valid=%b data=%h cnt=%0d expected 1 22 1",
               bValid, bData, bCnt); miscompares++;
    end
    tick();
    vectors++;
    if ({bValid, bCnt, aValid} !== {1'b0, 8'd2, 1'b0}) begin
      $display("FAIL bp_drain: got b_valid=%b b_cnt=%0d a_valid=%b expected 0 2 0",
               bValid, bCnt, aValid); miscompares++;
    end
  endtask

  task automatic test_streaming();
    logic [7:0] word;
    resetDut();
    aReady = 1'b1; bReady = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      word = 8'(i);
      inData = word; inSel = (i % 2 == 0); inValid = 1'b1;
      #1;
      vectors++;
      if (inReady !== 1'b1) begin
        $display("FAIL stream_ready_%0d: got %b expected 1", i, inReady); miscompares++;
      end
      tick();
      vectors++;
      if (inSel == 1'b0) begin
        if ({aValid, aData, bValid} !== {1'b1, word, 1'b0}) begin
          $display("FAIL stream_word_%0d: got a_valid=%b a_data=%h b_valid=%b expected 1 %h 0",
                   i, aValid, aData, bValid, word); miscompares++;
        end
      end else begin
        if ({bValid, bData, aValid} !== {1'b1, word, 1'b0}) begin
          $display("FAIL stream_word_%0d: got b_valid=%b b_data=%h a_valid=%b expected 1 %h 0",
                   i, bValid, bData, aValid, word); miscompares++;
        end
      end
    end
    inValid = 1'b0;
    tick();
    vectors++;
    if ({aCnt, bCnt, aValid, bValid} !== {8'd3, 8'd3, 2'b00}) begin
      $display("FAIL stream_counts: got a_cnt=%0d b_cnt=%0d valids=%b%b expected 3 3 00",
               aCnt, bCnt, aValid, bValid); miscompares++;
    end
  endtask

  task automatic test_independence();
    logic [7:0] word;
    resetDut();
    aReady = 1'b0; bReady = 1'b1;
    inData = 8'h77; inSel = 1'b0; inValid = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      word = 8'hB0 + 8'(i);
      inData = word; inSel = 1'b1;
      #1;
      vectors++;
      if (inReady !== 1'b1) begin
        $display("FAIL indep_ready_%0d: got %b expected 1", i, inReady); miscompares++;
      end
      tick();
      vectors++;
      if ({bValid, bData, aValid, aData} !== {1'b1, word, 1'b1, 8'h77}) begin
        $display("FAIL indep_word_%0d: got b=%b/%h a=%b/%h expected 1/%h 1/77",
                 i, bValid, bData, aValid, aData, word); miscompares++;
      end
    end
    inValid = 1'b0; inSel = 1'b0;
    #1;
    vectors++;
    if (inReady !== 1'b0) begin
      $display("FAIL indep_a_blocked: got %b expected 0", inReady); miscompares++;
    end
    tick();
    vectors++;
    if ({bCnt, aCnt, aValid} !== {8'd3, 8'd0, 1'b1}) begin
      $display("FAIL indep_counts: got b_cnt=%0d a_cnt=%0d a_valid=%b expected 3 0 1",
               bCnt, aCnt, aValid); miscompares++;
    end
  endtask

  task automatic test_wrap();
    resetDut();
    aReady = 1'b1; inSel = 1'b0; inValid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      inData = 8'(i);
      tick();
    end
    vectors++;
    if ({aCnt, aValid, aData} !== {8'd255, 1'b1, 8'hFF}) begin
      $display("FAIL wrap_all_ones: got cnt=%0d valid=%b data=%h expected 255 1 ff",
               aCnt, aValid, aData); miscompares++;
    end
    inValid = 1'b0;
    tick();
    vectors++;
    if ({aCnt, aValid} !== {8'd0, 1'b0}) begin
      $display("FAIL wrap_zero: got cnt=%0d valid=%b expected 0 0", aCnt, aValid); miscompares++;
    end
  endtask

  task automatic test_mid_reset();
    resetDut();
    aReady = 1'b0; inSel = 1'b0; inData = 8'h3C; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    vectors++;
    if ({aValid, aData} !== {1'b1, 8'h3C}) begin
      $display("FAIL midrst_loaded: got valid=%b data=%h expected 1 3c", aValid, aData); miscompares++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({aValid, aData, aCnt} !== {1'b0, 8'h00, 8'd0}) begin
      $display("FAIL midrst_cleared: got valid=%b data=%h cnt=%0d expected 0 00 0",
               aValid, aData, aCnt); miscompares++;
    end
    aReady = 1'b1;
    tick();
    vectors++;
    if ({aValid, aCnt} !== {1'b0, 8'd0}) begin
      $display("FAIL midrst_no_delivery: got valid=%b cnt=%0d expected 0 0", aValid, aCnt); miscompares++;
    end
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inSel = 1'b0; inData = 8'h00;
    aReady = 1'b0; bReady = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_independence();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
